// File: rtl/race_start_sequencer.sv
// Two-lane drag-race start sequencer: staging, red/yellow countdown, foul detection, winner/reaction timing.
// Latency: lights follow the registered state; results appear the cycle after the deciding sampling edge.
// Backpressure: none; results are held in DONE until clear is sampled high.
module race_start_sequencer #(
  parameter int RED_CYCLES     = 4,
  parameter int YEL_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stage_a,
  input  logic             stage_b,
  input  logic             start,
  input  logic             launch_a,
  input  logic             launch_b,
  input  logic             clear,
  output logic             red,
  output logic             yellow,
  output logic             green,
  output logic             win_a,
  output logic             win_b,
  output logic             foul_a,
  output logic             foul_b,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] react_time
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAGED,
    S_RED,
    S_YELLOW,
    S_GREEN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] RED_LOAD = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(YEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             win_a_nxt, win_b_nxt, foul_a_nxt, foul_b_nxt, timeout_nxt;
  logic [CNT_W-1:0] react_nxt;
  logic             any_launch;

  assign any_launch = launch_a | launch_b;

  // State, counter and registered result flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      win_a      <= 1'b0;
      win_b      <= 1'b0;
      foul_a     <= 1'b0;
      foul_b     <= 1'b0;
      timeout    <= 1'b0;
      react_time <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      win_a      <= win_a_nxt;
      win_b      <= win_b_nxt;
      foul_a     <= foul_a_nxt;
      foul_b     <= foul_b_nxt;
      timeout    <= timeout_nxt;
      react_time <= react_nxt;
    end
  end

  // Next-state, counter and result decisions; launch beats countdown expiry on the same edge
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    win_a_nxt   = win_a;
    win_b_nxt   = win_b;
    foul_a_nxt  = foul_a;
    foul_b_nxt  = foul_b;
    timeout_nxt = timeout;
    react_nxt   = react_time;
    case (state)
      S_IDLE: begin
        if (stage_a && stage_b) state_nxt = S_STAGED;
      end
      S_STAGED: begin
        if (!(stage_a && stage_b)) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          state_nxt = S_RED;
          cnt_nxt   = RED_LOAD;
        end
      end
      S_RED, S_YELLOW: begin
        if (any_launch) begin
          // A lone fouler hands the win to the other lane with zero reaction time
          state_nxt  = S_DONE;
          cnt_nxt    = '0;
          foul_a_nxt = launch_a;
          foul_b_nxt = launch_b;
          win_a_nxt  = launch_b & ~launch_a;
          win_b_nxt  = launch_a & ~launch_b;
          react_nxt  = '0;
        end else if (cnt == '0) begin
          state_nxt = (state == S_RED) ? S_YELLOW : S_GREEN;
          cnt_nxt   = (state == S_RED) ? YEL_LOAD : '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_GREEN: begin
        if (any_launch) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
          win_a_nxt = launch_a;
          win_b_nxt = launch_b;
          react_nxt = cnt;
        end else if (cnt == TO_LAST) begin
          state_nxt   = S_DONE;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (clear) begin
          state_nxt   = S_IDLE;
          cnt_nxt     = '0;
          win_a_nxt   = 1'b0;
          win_b_nxt   = 1'b0;
          foul_a_nxt  = 1'b0;
          foul_b_nxt  = 1'b0;
          timeout_nxt = 1'b0;
          react_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore light tree and busy decode
  always_comb begin
    red    = (state == S_RED);
    yellow = (state == S_YELLOW);
    green  = (state == S_GREEN);
    busy   = (state != S_IDLE);
  end

endmodule

// File: tb/tb_race_start_sequencer.sv
module tb_race_start_sequencer;

  localparam int RED = 4;
  localparam int YEL = 3;
  localparam int TO  = 20;
  localparam int W   = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         stage_a, stage_b, start, launch_a, launch_b, clear;
  logic         red, yellow, green, win_a, win_b, foul_a, foul_b, timeout, busy;
  logic [W-1:0] react_time;

  int n_checks = 0;
  int n_fail   = 0;

  race_start_sequencer #(
    .RED_CYCLES(RED), .YEL_CYCLES(YEL), .TIMEOUT_CYCLES(TO), .CNT_W(W)
  ) dut (
    .clk(clk), .rst(rst),
    .stage_a(stage_a), .stage_b(stage_b), .start(start),
    .launch_a(launch_a), .launch_b(launch_b), .clear(clear),
    .red(red), .yellow(yellow), .green(green),
    .win_a(win_a), .win_b(win_b), .foul_a(foul_a), .foul_b(foul_b),
    .timeout(timeout), .busy(busy), .react_time(react_time)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: cycle t after the start edge is red for t<RED, yellow up to RED+YEL, then green.
  // la/lb: cycle in which each lane raises (and holds) launch, -1 for never.
  task automatic do_race(input int la, input int lb, input bit drop_stage, input string name);
    int first, done_t;
    logic [2:0] exp_l;
    logic [4:0] exp_f;
    logic [W-1:0] exp_rt;
    logic ea, eb, fa, fb, et;
    first = 100000;
    if (la >= 0) first = la;
    if (lb >= 0 && lb < first) first = lb;
    ea = 0; eb = 0; fa = 0; fb = 0; et = 0; exp_rt = '0;
    if (first < RED + YEL) begin
      fa = (la == first); fb = (lb == first);
      ea = fb && !fa;     eb = fa && !fb;
      done_t = first + 1;
    end else if (first < RED + YEL + TO) begin
      ea = (la == first); eb = (lb == first);
      exp_rt = W'(first - (RED + YEL));
      done_t = first + 1;
    end else begin
      et = 1; done_t = RED + YEL + TO;
    end
    exp_f = {ea, eb, fa, fb, et};

    stage_a = 1; stage_b = 1;
    tick();
    n_checks++;
    if ({busy, red, yellow, green} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s staged: got busy/r/y/g %b want 1000", name, {busy, red, yellow, green});
    end
    start = 1;
    tick();
    start = 0;
    if (drop_stage) begin stage_a = 0; stage_b = 0; end

    for (int t = 0; t <= done_t; t++) begin
      if (t < done_t) begin
        exp_l = (t < RED) ? 3'b100 : (t < RED + YEL) ? 3'b010 : 3'b001;
        n_checks++;
        if ({red, yellow, green} !== exp_l || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s lights t=%0d: got r/y/g %b busy %b want %b busy 1", name, t, {red, yellow, green}, busy, exp_l);
        end
        n_checks++;
        if ({win_a, win_b, foul_a, foul_b, timeout} !== 5'b0 || react_time !== '0) begin
          n_fail++;
          $display("FAIL %s early_result t=%0d: got flags %b rt %0d want 0", name, t, {win_a, win_b, foul_a, foul_b, timeout}, react_time);
        end
        launch_a = (la >= 0 && t >= la);
        launch_b = (lb >= 0 && t >= lb);
        tick();
      end else begin
        n_checks++;
        if ({red, yellow, green} !== 3'b000 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done_lights: got r/y/g %b busy %b want 000 busy 1", name, {red, yellow, green}, busy);
        end
        n_checks++;
        if ({win_a, win_b, foul_a, foul_b, timeout} !== exp_f || react_time !== exp_rt) begin
          n_fail++;
          $display("FAIL %s result: got wa/wb/fa/fb/to %b rt %0d want %b rt %0d", name, {win_a, win_b, foul_a, foul_b, timeout}, react_time, exp_f, exp_rt);
        end
      end
    end

    // Results hold in DONE while clear is low, regardless of start/stage activity
    start = 1;
    for (int h = 0; h < 2; h++) begin
      tick();
      n_checks++;
      if ({win_a, win_b, foul_a, foul_b, timeout} !== exp_f || react_time !== exp_rt || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s hold: got flags %b rt %0d busy %b want %b rt %0d busy 1", name, {win_a, win_b, foul_a, foul_b, timeout}, react_time, busy, exp_f, exp_rt);
      end
    end
    start = 0; launch_a = 0; launch_b = 0; stage_a = 0; stage_b = 0;
    clear = 1;
    tick();
    clear = 0;
    n_checks++;
    if ({win_a, win_b, foul_a, foul_b, timeout, busy, red, yellow, green} !== 9'b0 || react_time !== '0) begin
      n_fail++;
      $display("FAIL %s clear: got flags %b busy %b rt %0d want all 0", name, {win_a, win_b, foul_a, foul_b, timeout}, busy, react_time);
    end
  endtask

  task automatic test_reset();
    rst = 0; stage_a = 0; stage_b = 0; start = 0; launch_a = 0; launch_b = 0; clear = 0;
    #12;
    n_checks++;
    if ({red, yellow, green, win_a, win_b, foul_a, foul_b, timeout, busy} !== 9'b0 || react_time !== '0) begin
      n_fail++;
      $display("FAIL reset: got outputs %b rt %0d want all 0", {red, yellow, green, win_a, win_b, foul_a, foul_b, timeout, busy}, react_time);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_normal_race();
    do_race(-1, RED + YEL + 5, 0, "normal");
  endtask

  task automatic test_false_start();
    do_race(RED + 1, -1, 0, "false_start");
  endtask

  task automatic test_simultaneous();
    do_race(RED + YEL + 3, RED + YEL + 3, 0, "tie_green");
    do_race(1, 1, 0, "both_foul");
    do_race(RED + YEL - 1, -1, 0, "foul_last_yellow");
    do_race(-1, RED - 1, 0, "foul_last_red");
    do_race(RED + YEL, -1, 0, "first_green");
    do_race(RED + YEL + TO - 1, -1, 1, "last_green");
  endtask

  task automatic test_timeout();
    do_race(-1, -1, 0, "timeout");
  endtask

  task automatic test_staging_abort();
    stage_a = 1; stage_b = 1;
    tick();
    stage_a = 0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stage_drop: got busy %b want 0", busy);
    end
    stage_a = 0; stage_b = 1; start = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({busy, red, yellow, green} !== 4'b0) begin
        n_fail++;
        $display("FAIL one_lane_start i=%0d: got busy/r/y/g %b want 0000", i, {busy, red, yellow, green});
      end
    end
    start = 0; stage_b = 0;
    tick();
  endtask

  task automatic test_reset_midrace();
    stage_a = 1; stage_b = 1;
    tick();
    start = 1;
    tick();
    start = 0;
    repeat (RED + 1) tick();
    n_checks++;
    if (yellow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_yellow: got yellow %b want 1", yellow);
    end
    #2 rst = 0;
    #1;
    n_checks++;
    if ({red, yellow, green, win_a, win_b, foul_a, foul_b, timeout, busy} !== 9'b0 || react_time !== '0) begin
      n_fail++;
      $display("FAIL reset_yellow: got outputs %b want all 0", {red, yellow, green, win_a, win_b, foul_a, foul_b, timeout, busy});
    end
    stage_a = 0; stage_b = 0; start = 1;
    #3 rst = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({busy, red, yellow, green} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset i=%0d: got busy/r/y/g %b want 0000", i, {busy, red, yellow, green});
      end
    end
    start = 0;
    // Reset also wipes held results in DONE
    stage_a = 1; stage_b = 1;
    tick();
    start = 1;
    tick();
    start = 0; launch_a = 1;
    tick();
    n_checks++;
    if ({win_b, foul_a} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_done: got win_b/foul_a %b want 11", {win_b, foul_a});
    end
    #2 rst = 0;
    #1;
    n_checks++;
    if ({win_a, win_b, foul_a, foul_b, timeout, busy} !== 6'b0 || react_time !== '0) begin
      n_fail++;
      $display("FAIL reset_done: got flags %b busy %b want 0", {win_a, win_b, foul_a, foul_b, timeout}, busy);
    end
    launch_a = 0; stage_a = 0; stage_b = 0;
    #3 rst = 1;
    tick();
  endtask

  task automatic test_random_races();
    int la, lb;
    for (int r = 0; r < 40; r++) begin
      la = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, RED + YEL + TO + 2));
      lb = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, RED + YEL + TO + 2));
      if ($urandom_range(0, 3) == 0) lb = la;
      do_race(la, lb, bit'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_normal_race();
    test_false_start();
    test_simultaneous();
    test_timeout();
    test_staging_abort();
    test_reset_midrace();
    test_random_races();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/race_start_sequencer.md
# race_start_sequencer

Two-lane drag-race start sequencer that drives the red/yellow/green light tree and arbitrates the race between lane A and lane B. It runs the staging handshake, the timed red/yellow countdown, and false-start (foul) detection. It decides the winner on green, reports the winner's reaction time in clock cycles, and holds the result until cleared. It sits between the track sensors/start button and the light-tree outputs, replacing the free-running light controller with a race-aware scheduler.

## Interface
- `RED_CYCLES`, default 4: cycles red is lit, ≥1.
- `YEL_CYCLES`, default 3: cycles yellow is lit, ≥1.
- `TIMEOUT_CYCLES`, default 20: green cycles with no launch before abort, ≥1, < 2^CNT_W.
- `CNT_W`, default 8: width of the countdown/reaction counter and `react_time`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset; asserting it forces IDLE immediately.
- `stage_a`, `stage_b` in 1: lane car staged (level).
- `start` in 1: race start request (level, sampled).
- `launch_a`, `launch_b` in 1: lane car has left the line (level, sampled).
- `clear` in 1: acknowledge result, return to IDLE.
- `red`, `yellow`, `green` out 1: light tree.
- `win_a`, `win_b` out 1: lane winner flags (both high = tie).
- `foul_a`, `foul_b` out 1: lane false-start flags.
- `timeout` out 1: race aborted, no launch on green.
- `busy` out 1: high in every state except IDLE.
- `react_time` out CNT_W: winner's reaction count; 0 when no winner.

## Operation
- Reset: state IDLE. All outputs are 0, `react_time`=0, and the counter is 0.
- Lights and `busy` decode from the registered state (Moore). Result flags and `react_time` are registered and change only on entry to DONE or IDLE.
- IDLE: all lights off. `stage_a & stage_b` sampled high → STAGED.
- STAGED: lights off. Either stage low → IDLE. Otherwise `start` high → RED, counter ← RED_CYCLES-1.
- RED: `red`=1. The counter decrements each cycle. At 0 → YELLOW, counter ← YEL_CYCLES-1.
- YELLOW: `yellow`=1. It counts down the same way as RED. At 0 → GREEN, counter ← 0.
- Foul detection in RED/YELLOW: `launch_x` sampled high → DONE.
  - The offending lane's `foul_x`=1.
  - If only one lane fouled, the other lane's `win_x`=1 and `react_time`=0.
  - If both lanes fouled on the same edge, both fouls are set and there is no winner.
- GREEN: `green`=1. The counter increments each cycle from 0.
  - First edge where any launch is sampled → DONE. Every lane launching on that edge gets `win_x`=1 (same edge = tie), and `react_time` = counter value at that edge.
  - No launch and counter == TIMEOUT_CYCLES-1 → DONE with `timeout`=1.
- DONE: lights off, `busy`=1, results held. `clear` sampled high → IDLE; all result flags and `react_time` are zeroed on that edge.
- `start` is ignored outside STAGED. `clear` is ignored outside DONE. Stage drops are ignored after STAGED.
- Counter is CNT_W bits and never wraps: the GREEN timeout bound guarantees this.

## Timing
- STAGED→RED: the edge sampling `start`. `red` is high for exactly RED_CYCLES cycles, then `yellow` for exactly YEL_CYCLES cycles, with no gap or overlap.
- At most one light is high in any cycle.
- Launch in GREEN: result is visible the cycle after the sampling edge. A launch sampled on the first GREEN edge gives `react_time`=0.
- Max green duration is TIMEOUT_CYCLES cycles.
- Reset mid-race: all outputs go to 0 asynchronously. After release, the block waits in IDLE; a held `start` alone does not restart it without re-staging.
- Sampling launch in RED/YELLOW takes precedence over the countdown reaching 0 on the same edge.

## Test plan
Parameters for all scenarios: RED=4, YEL=3, TIMEOUT=20, CNT_W=8.
- **Normal race:** stage both, pulse `start`, assert `launch_b` on the 6th GREEN cycle. Expect red 4 cycles, yellow 3, green 6, then `win_b`=1, `react_time`=5, `win_a`=0, `busy`=1. `clear` → all 0.
- **False start:** `launch_a` on the 2nd yellow cycle. Expect DONE next cycle, `foul_a`=1, `win_b`=1, `react_time`=0, and green is never lit.
- **Simultaneous events:** both launch on the same GREEN edge (counter 3) → `win_a`=`win_b`=1, `react_time`=3. Both launch during RED → `foul_a`=`foul_b`=1, no winner.
- **Timeout:** no launch → green exactly 20 cycles, then `timeout`=1, no win, `react_time`=0.
- **Staging abort:** `stage_a` drops in STAGED → IDLE. `start` in IDLE with one lane staged → no lights.
- **Reset during YELLOW:** `rst` low mid-cycle → outputs 0 before the next edge. After release with `start` held high and lanes unstaged, the block stays in IDLE.
